// File: rtl/permutation_inv_pkg.sv
// Shared types, constants and helpers for the iterative inverse Ascon permutation.
package permutation_inv_pkg;

  typedef logic [0:4][63:0] ascon_state;
  typedef logic [3:0]       round_t;

  typedef enum logic [1:0] {IDLE, LIN, SBOX, DONE} inv_fsm_t;

  localparam logic [5:0] ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [5:0] ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  localparam logic [4:0] INV_SBOX [32] = '{
    5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
    5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
    5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
    5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
  };

  function automatic logic [7:0] round_const(round_t r);
    return {~r, r};
  endfunction

  function automatic logic [63:0] ror64(logic [63:0] x, logic [5:0] amt);
    logic [127:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[63:0];
  endfunction

endpackage

// File: rtl/permutation_inv_if.sv
// Valid/ready request and response channels of the inverse permutation.
interface permutation_inv_if;

  logic                          in_valid;
  logic                          in_ready;
  logic [3:0]                    num_rounds;
  permutation_inv_pkg::ascon_state in_state;
  logic                          out_valid;
  logic                          out_ready;
  permutation_inv_pkg::ascon_state out_state;

  modport master (
    output in_valid, num_rounds, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, num_rounds, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/permutation_inv_pl_inv_step.sv
// One factor L_k of the inverse linear layer, applied to all five state words.
module pl_inv_step
  import permutation_inv_pkg::*;
(
  input  ascon_state s_i,
  input  logic [2:0] k_i,
  output ascon_state s_o
);

  // Rotation amounts 2^k*a mod 64 come from the 6-bit shift truncating.
  always_comb begin
    s_o = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      s_o[i] = s_i[i] ^ ror64(s_i[i], ROT_A[i] << k_i) ^ ror64(s_i[i], ROT_B[i] << k_i);
    end
  end

endmodule

// File: rtl/permutation_inv.sv
// Iterative inverse Ascon permutation (p^n)^-1, n = 1..MAX_ROUNDS.
// ASCON_PERM_INV_FAST_LINEAR_EN: full inverse linear layer per cycle (one cycle per round).
module permutation_inv
  import permutation_inv_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = 12
) (
  input logic               clk,
  input logic               rst,
  permutation_inv_if.slave  perm_if
);

  localparam logic [3:0] MAX_N = 4'(MAX_ROUNDS);

  inv_fsm_t   fsm_q;
  ascon_state state_q;
  round_t     r_q;
  logic [3:0] rounds_left_q;
  logic [2:0] k_q;
  logic       in_ready_q;
  logic       out_valid_q;

  logic [3:0] n_clamped;
  ascon_state sbox_in;
  ascon_state sbox_out;
  logic [4:0] col;
  logic [4:0] sub;

  assign n_clamped = (perm_if.num_rounds == 4'd0 || perm_if.num_rounds > MAX_N)
                   ? MAX_N : perm_if.num_rounds;

`ifdef ASCON_PERM_INV_FAST_LINEAR_EN
  ascon_state chain [7];
  assign chain[0] = state_q;
  for (genvar g = 0; g < 6; g++) begin : g_lin
    pl_inv_step u_step (.s_i(chain[g]), .k_i(3'(g)), .s_o(chain[g+1]));
  end
  assign sbox_in = chain[6];
`else
  ascon_state lin_out;
  pl_inv_step u_step (.s_i(state_q), .k_i(k_q), .s_o(lin_out));
  assign sbox_in = state_q;
`endif

  always_comb begin
    sbox_out = '0;
    col      = '0;
    sub      = '0;
    for (int unsigned j = 0; j < 64; j++) begin
      col = {sbox_in[0][j], sbox_in[1][j], sbox_in[2][j], sbox_in[3][j], sbox_in[4][j]};
      sub = INV_SBOX[col];
      sbox_out[0][j] = sub[4];
      sbox_out[1][j] = sub[3];
      sbox_out[2][j] = sub[2];
      sbox_out[3][j] = sub[1];
      sbox_out[4][j] = sub[0];
    end
    sbox_out[2][7:0] = sbox_out[2][7:0] ^ round_const(r_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= IDLE;
      state_q       <= '0;
      r_q           <= '0;
      rounds_left_q <= '0;
      k_q           <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (perm_if.in_valid) begin
            state_q       <= perm_if.in_state;
            r_q           <= 4'd11;
            rounds_left_q <= n_clamped;
            k_q           <= '0;
            in_ready_q    <= 1'b0;
`ifdef ASCON_PERM_INV_FAST_LINEAR_EN
            fsm_q         <= SBOX;
`else
            fsm_q         <= LIN;
`endif
          end
        end
        LIN: begin
`ifndef ASCON_PERM_INV_FAST_LINEAR_EN
          state_q <= lin_out;
`endif
          k_q <= k_q + 3'd1;
          if (k_q == 3'd5) fsm_q <= SBOX;
        end
        SBOX: begin
          state_q       <= sbox_out;
          rounds_left_q <= rounds_left_q - 4'd1;
          r_q           <= r_q - 4'd1;
          k_q           <= '0;
          if (rounds_left_q == 4'd1) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
`ifdef ASCON_PERM_INV_FAST_LINEAR_EN
            fsm_q <= SBOX;
`else
            fsm_q <= LIN;
`endif
          end
        end
        DONE: begin
          if (perm_if.out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign perm_if.in_ready  = in_ready_q;
  assign perm_if.out_valid = out_valid_q;
  assign perm_if.out_state = state_q;

endmodule

// File: tb/tb_permutation_inv.sv
// Bench for permutation_inv: forward Ascon reference model, vector table and corner sequences.
module tb_permutation_inv;

  typedef logic [319:0] st_t;
  typedef struct {
    st_t        in_state;
    logic [3:0] n;
    st_t        exp;
  } vec_t;

  localparam int SBOX [32] = '{
    'h04, 'h0b, 'h1f, 'h14, 'h1a, 'h15, 'h09, 'h02,
    'h1b, 'h05, 'h08, 'h12, 'h1d, 'h03, 'h06, 'h1c,
    'h1e, 'h13, 'h07, 'h0e, 'h00, 'h0d, 'h11, 'h18,
    'h10, 'h0c, 'h01, 'h19, 'h16, 'h0a, 'h0f, 'h17
  };
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  permutation_inv_if bus();
  permutation_inv #(.MAX_ROUNDS(12)) dut (.clk(clk), .rst(rst), .perm_if(bus));

  st_t        step_in;
  st_t        step_out;
  logic [2:0] step_k;
  pl_inv_step u_step (.s_i(step_in), .k_i(step_k), .s_o(step_out));

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [63:0] rotr(logic [63:0] x, int a);
    return (x >> a) | (x << (64 - a));
  endfunction

  function automatic logic [63:0] sigma(int i, logic [63:0] x);
    return x ^ rotr(x, RA[i]) ^ rotr(x, RB[i]);
  endfunction

  // Forward round r: add constant, substitute columns, diffuse words.
  function automatic st_t fwd_round(st_t s, int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    int idx;
    int v;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    x[2][7:0] ^= 8'(((15 - r) * 16) + r);
    for (int i = 0; i < 5; i++) y[i] = '0;
    for (int j = 0; j < 64; j++) begin
      idx = 0;
      for (int i = 0; i < 5; i++) idx = idx * 2 + int'(x[i][j]);
      v = SBOX[idx];
      for (int i = 0; i < 5; i++) y[i][j] = v[4-i];
    end
    for (int i = 0; i < 5; i++) x[i] = sigma(i, y[i]);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic st_t fwd_perm(st_t s, int n);
    for (int r = 12 - n; r < 12; r++) s = fwd_round(s, r);
    return s;
  endfunction

  function automatic int eff_n(logic [3:0] n);
    return (n == 4'd0 || n > 4'd12) ? 12 : int'(n);
  endfunction

  function automatic int exp_lat(int n);
`ifdef ASCON_PERM_INV_FAST_LINEAR_EN
    return n;
`else
    return 7 * n;
`endif
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic chk(input string nm, input st_t act, input st_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic start_job(input st_t s, input logic [3:0] n);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_total++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.in_valid   = 1'b1;
    bus.in_state   = s;
    bus.num_rounds = n;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [10];
    logic [3:0]  ns [10];
    st_t         x;
    st_t         held;
    logic [63:0] xs [4];
    int          lat;

    ns = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd11, 4'd12, 4'd0, 4'd15};
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.num_rounds = '0;
    bus.in_state   = '0;
    step_in        = '0;
    step_k         = '0;

    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("reset_in_ready", bus.in_ready, 1'b1);
    chk_bit("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_state", bus.out_state, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      x = rand_st();
      vecs[i].n        = ns[i];
      vecs[i].in_state = fwd_perm(x, eff_n(ns[i]));
      vecs[i].exp      = x;
    end
    for (int i = 0; i < 10; i++) begin
      start_job(vecs[i].in_state, vecs[i].n);
      wait_done(lat);
      chk_int($sformatf("latency_n%0d", vecs[i].n), lat, exp_lat(eff_n(vecs[i].n)));
      chk($sformatf("result_n%0d", vecs[i].n), bus.out_state, vecs[i].exp);
      accept_out();
    end

    // Known initial state IV||K||N rewound through eight rounds.
    x = {64'h00001000808c0001, 128'h000102030405060708090a0b0c0d0e0f,
         128'hf0e0d0c0b0a090807060504030201000};
    start_job(fwd_perm(x, 8), 4'd8);
    wait_done(lat);
    chk_int("iv_latency_n8", lat, exp_lat(8));
    chk("iv_result_n8", bus.out_state, x);
    accept_out();

    // Output stall with ignored input pulses.
    x = rand_st();
    start_job(fwd_perm(x, 12), 4'd12);
    wait_done(lat);
    held = x;
    chk("stall_result", bus.out_state, held);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid   = c[0];
      bus.in_state   = rand_st();
      bus.num_rounds = 4'd1;
      @(posedge clk);
      #1;
      chk("stall_hold", bus.out_state, held);
      chk_bit("stall_in_ready", bus.in_ready, 1'b0);
      chk_bit("stall_out_valid", bus.out_valid, 1'b1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    accept_out();
    chk_bit("post_hs_out_valid", bus.out_valid, 1'b0);
    chk_bit("post_hs_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk_bit("post_hs_idle", bus.in_ready, 1'b1);

    // Asynchronous reset in the middle of a job.
    start_job(fwd_perm(rand_st(), 12), 4'd12);
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_bit("midrst_out_valid", bus.out_valid, 1'b0);
    chk_bit("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_out_state", bus.out_state, '0);
    @(negedge clk);
    rst = 1'b0;
    x = rand_st();
    start_job(fwd_perm(x, 12), 4'd12);
    wait_done(lat);
    chk_int("after_rst_latency", lat, exp_lat(12));
    chk("after_rst_result", bus.out_state, x);
    accept_out();

    // L_0..L_5 undo Sigma on every word.
    xs[0] = 64'h1;
    xs[1] = 64'h8000_0000_0000_0000;
    xs[2] = {$urandom, $urandom};
    xs[3] = {$urandom, $urandom};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 5; i++) step_in[319-64*i -: 64] = sigma(i, xs[t]);
      for (int k = 0; k < 6; k++) begin
        step_k = 3'(k);
        #1;
        step_in = step_out;
      end
      chk($sformatf("pl_inv_step_%0d", t), step_in, {5{xs[t]}});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
